// File: rtl/pe_covariance_accumulator.sv
// Sigma-point covariance accumulator: sums w*d*d^T (upper triangle, Q16.16) over N_POINTS points.
// Optional build macro COV_ACC_SATURATE_EN selects saturating accumulation instead of wrap-around.
module pe_covariance_accumulator #(
  parameter int DIM_SIGMA = 5,
  parameter int N_POINTS  = 11,
  localparam int TRI      = DIM_SIGMA * (DIM_SIGMA + 1) / 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   pt_valid,
  output logic                   pt_ready,
  input  logic [31:0]            pt_weight,
  input  logic [DIM_SIGMA*32-1:0] pt_sigma,
  output logic                   cov_valid,
  input  logic                   cov_ready,
  output logic [TRI*32-1:0]      cov_out,
  output logic                   busy
);

  localparam int CW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic signed [31:0] acc_q   [TRI];
  logic signed [31:0] acc_upd [TRI];
  logic             accept;
  logic             clear;
  logic signed [63:0] w64;

  assign pt_ready  = (state_q == ACCUM);
  assign cov_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign accept    = pt_valid & pt_ready;
  assign w64       = {{32{pt_weight[31]}}, pt_weight};

  for (genvar i = 0; i < DIM_SIGMA; i++) begin : g_row
    for (genvar j = i; j < DIM_SIGMA; j++) begin : g_col
      // Row-major upper-triangle position of entry (i,j)
      localparam int IDX = i * DIM_SIGMA - (i * (i - 1)) / 2 + (j - i);
      logic signed [63:0] di, dj, prod;
      assign di   = {{32{pt_sigma[32*i+31]}}, pt_sigma[32*i +: 32]};
      assign dj   = {{32{pt_sigma[32*j+31]}}, pt_sigma[32*j +: 32]};
      assign prod = (di * dj) >>> 16;
`ifdef COV_ACC_SATURATE_EN
      localparam logic signed [63:0] MAXV = 64'sh0000_0000_7FFF_FFFF;
      localparam logic signed [63:0] MINV = -64'sh0000_0000_8000_0000;
      logic signed [63:0] term, sum;
      logic signed [31:0] upd;
      assign term = (w64 * prod) >>> 16;
      assign sum  = {{32{acc_q[IDX][31]}}, acc_q[IDX]} + term;
      always_comb begin
        upd = sum[31:0];
        if (sum > MAXV)      upd = 32'sh7FFF_FFFF;
        else if (sum < MINV) upd = 32'sh8000_0000;
      end
      assign acc_upd[IDX] = upd;
`else
      assign acc_upd[IDX] = acc_q[IDX] + 32'((w64 * prod) >>> 16);
`endif
      assign cov_out[32*IDX +: 32] = acc_q[IDX];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(N_POINTS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (cov_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < TRI; k++) acc_q[k] <= '0;
    end else if (clear) begin
      for (int unsigned k = 0; k < TRI; k++) acc_q[k] <= '0;
    end else if (accept) begin
      for (int unsigned k = 0; k < TRI; k++) acc_q[k] <= acc_upd[k];
    end
  end

endmodule

// File: tb/tb_pe_covariance_accumulator.sv
// Self-checking bench for pe_covariance_accumulator: random runs against an arithmetic
// reference model plus directed small-parameter cases (honours COV_ACC_SATURATE_EN).
module tb_pe_covariance_accumulator;

  localparam int DIM_A = 5;
  localparam int N_A   = 11;
  localparam int TRI_A = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic                   a_start, a_valid, a_pt_ready, a_cov_valid, a_cov_ready, a_busy;
  logic [31:0]            a_w;
  logic [DIM_A*32-1:0]    a_sigma;
  logic [TRI_A*32-1:0]    a_cov;

  logic                   b_start, b_valid, b_pt_ready, b_cov_valid, b_cov_ready, b_busy;
  logic [31:0]            b_w;
  logic [63:0]            b_sigma;
  logic [95:0]            b_cov;

  logic                   c_start, c_valid, c_pt_ready, c_cov_valid, c_cov_ready, c_busy;
  logic [31:0]            c_w;
  logic [31:0]            c_sigma;
  logic [31:0]            c_cov;

  pe_covariance_accumulator #(.DIM_SIGMA(DIM_A), .N_POINTS(N_A)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .pt_valid(a_valid), .pt_ready(a_pt_ready),
    .pt_weight(a_w), .pt_sigma(a_sigma), .cov_valid(a_cov_valid), .cov_ready(a_cov_ready),
    .cov_out(a_cov), .busy(a_busy));

  pe_covariance_accumulator #(.DIM_SIGMA(2), .N_POINTS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .pt_valid(b_valid), .pt_ready(b_pt_ready),
    .pt_weight(b_w), .pt_sigma(b_sigma), .cov_valid(b_cov_valid), .cov_ready(b_cov_ready),
    .cov_out(b_cov), .busy(b_busy));

  pe_covariance_accumulator #(.DIM_SIGMA(1), .N_POINTS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .pt_valid(c_valid), .pt_ready(c_pt_ready),
    .pt_weight(c_w), .pt_sigma(c_sigma), .cov_valid(c_cov_valid), .cov_ready(c_cov_ready),
    .cov_out(c_cov), .busy(c_busy));

  int checks = 0;
  int errors = 0;
  int mdl [TRI_A];
  int cur_w;
  int cur_d [DIM_A];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Weighted outer-product term in 64-bit fixed point
  function automatic longint term_f(input int w, input int di, input int dj);
    longint p, t;
    p = (longint'(di) * longint'(dj)) >>> 16;
    t = (longint'(w) * p) >>> 16;
    return t;
  endfunction

  function automatic int acc_add(input int acc, input longint t);
`ifdef COV_ACC_SATURATE_EN
    longint s;
    s = longint'(acc) + t;
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return int'(s);
`else
    return acc + int'(t);
`endif
  endfunction

  task automatic model_point();
    int k;
    k = 0;
    for (int i = 0; i < DIM_A; i++)
      for (int j = i; j < DIM_A; j++) begin
        mdl[k] = acc_add(mdl[k], term_f(cur_w, cur_d[i], cur_d[j]));
        k++;
      end
  endtask

  task automatic clear_model();
    for (int k = 0; k < TRI_A; k++) mdl[k] = 0;
  endtask

  task automatic check_cov_a(input string tag);
    for (int k = 0; k < TRI_A; k++)
      check($sformatf("%s[%0d]", tag, k), a_cov[k*32 +: 32], mdl[k]);
  endtask

  task automatic drive_point(input int mode);
    cur_w = (mode == 0) ? int'($urandom) : 32'h0000_1000;
    for (int k = 0; k < DIM_A; k++) cur_d[k] = (mode == 0) ? int'($urandom) : 32'h0001_0000;
    a_w = cur_w;
    for (int k = 0; k < DIM_A; k++) a_sigma[k*32 +: 32] = cur_d[k];
  endtask

  task automatic start_a(input bit with_valid);
    if (with_valid) drive_point(1);
    a_start = 1'b1;
    a_valid = with_valid;
    check("pt_ready_idle", a_pt_ready, 0);
    tick();
    a_start = 1'b0;
    a_valid = 1'b0;
    clear_model();
    check("busy_after_start", a_busy, 1);
  endtask

  task automatic run_a(input int mode, input int n_acc);
    int accepted;
    int cyc;
    accepted = 0;
    cyc = 0;
    while (accepted < n_acc && cyc < 400) begin
      drive_point(mode);
      a_valid = (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      check("pt_ready_accum", a_pt_ready, 1);
      check("cov_valid_accum", a_cov_valid, 0);
      if (a_valid) begin
        model_point();
        accepted++;
      end
      tick();
      cyc++;
    end
    a_valid = 1'b0;
    check("accept_budget", accepted, n_acc);
  endtask

  task automatic check_done_a(input string tag);
    check({tag, "_cov_valid"}, a_cov_valid, 1);
    check({tag, "_pt_ready"}, a_pt_ready, 0);
    check({tag, "_busy"}, a_busy, 1);
    check_cov_a(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    {a_start, a_valid, a_cov_ready, b_start, b_valid, b_cov_ready, c_start, c_valid, c_cov_ready} = '0;
    a_w = '0; a_sigma = '0; b_w = '0; b_sigma = '0; c_w = '0; c_sigma = '0;
    clear_model();
    #3;
    check("rst_pt_ready", a_pt_ready, 0);
    check("rst_cov_valid", a_cov_valid, 0);
    check("rst_busy", a_busy, 0);
    check_cov_a("rst_cov");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", a_busy, 0);

    // Random run, then DONE held with cov_ready low and stray start pulses
    start_a(0);
    check_cov_a("clear");
    run_a(0, N_A);
    check_done_a("done1");
    for (int c = 0; c < 10; c++) begin
      a_start = (c % 3 == 1);
      tick();
      check_done_a($sformatf("hold%0d", c));
    end
    a_start = 1'b0;
    a_cov_ready = 1'b1;
    tick();
    a_cov_ready = 1'b0;
    check("handshake_cov_valid", a_cov_valid, 0);
    check("handshake_busy", a_busy, 0);
    check_cov_a("retained");

    // Start with coincident point, toggled valid, cov_ready already high on DONE entry
    start_a(1);
    a_cov_ready = 1'b1;
    run_a(1, N_A);
    check_done_a("done2");
    for (int k = 0; k < TRI_A; k++)
      check($sformatf("b000[%0d]", k), a_cov[k*32 +: 32], 32'h0000_B000);
    tick();
    a_cov_ready = 1'b0;
    check("ready_early_cov_valid", a_cov_valid, 0);
    check("ready_early_busy", a_busy, 0);

    // Asynchronous reset after 3 points, then a clean run
    start_a(0);
    run_a(0, 3);
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    check("midrst_pt_ready", a_pt_ready, 0);
    check("midrst_cov_valid", a_cov_valid, 0);
    check("midrst_busy", a_busy, 0);
    check_cov_a("midrst_cov");
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("postrst_cov_valid", a_cov_valid, 0);
      check("postrst_busy", a_busy, 0);
    end
    start_a(0);
    run_a(0, N_A);
    check_done_a("done3");
    a_cov_ready = 1'b1;
    tick();
    a_cov_ready = 1'b0;
    check("done3_idle", a_busy, 0);

    // DIM_SIGMA=2, N_POINTS=1 directed vector
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("b_busy", b_busy, 1);
    check("b_pt_ready", b_pt_ready, 1);
    b_valid = 1'b1;
    b_w = 32'h0000_8000;
    b_sigma = {32'hFFFF_0000, 32'h0002_0000};
    tick();
    b_valid = 1'b0;
    check("b_cov_valid", b_cov_valid, 1);
    check("b_e00", b_cov[31:0], 32'h0002_0000);
    check("b_e01", b_cov[63:32], 32'hFFFF_0000);
    check("b_e11", b_cov[95:64], 32'h0000_8000);
    b_cov_ready = 1'b1;
    tick();
    b_cov_ready = 1'b0;
    check("b_idle", b_busy, 0);

    // Overflow of a single entry
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    c_valid = 1'b1;
    c_w = 32'h0001_0000;
    c_sigma = 32'h00C0_0000;
    tick();
    check("c_mid_cov_valid", c_cov_valid, 0);
`ifdef COV_ACC_SATURATE_EN
    check("c_first", c_cov, 32'h7FFF_FFFF);
`else
    check("c_first", c_cov, 32'h9000_0000);
`endif
    tick();
    c_valid = 1'b0;
    check("c_cov_valid", c_cov_valid, 1);
`ifdef COV_ACC_SATURATE_EN
    check("c_final", c_cov, 32'h7FFF_FFFF);
`else
    check("c_final", c_cov, 32'h2000_0000);
`endif
    c_cov_ready = 1'b1;
    tick();
    c_cov_ready = 1'b0;
    check("c_idle", c_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
